// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, parity rule and default oversampling.
// The transmitter and receiver both import this so they always agree on the frame format.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned PARITY_MAX_W   = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Zero-extending the data does not change its parity, so narrower words are simply widened.
  function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] data, input logic p_sel);
    return p_sel ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; both stages reset to 1
// so an idle-high line does not look like an edge coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_BITS data (LSB first), parity, stop.
// Samples mid-bit, reports the byte with a one-cycle valid strobe and error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 bclk_rx,
  input  logic                 p_sel,
  output logic [DATA_BITS-1:0] d_out_rx,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 mid_start;
  logic                 bit_end;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign mid_start = bclk_rx && (cnt_q == CNT_HALF);
  assign bit_end   = bclk_rx && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      armed_q   <= 1'b1;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      armed_q   <= armed_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Any high on the synchronized line re-arms start detection after a framing error.
  always_comb begin
    state_d   = state_q;
    cnt_d     = bclk_rx ? cnt_q + CNT_W'(1) : cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    armed_d   = armed_q | rx_s;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s && armed_q) state_d = ST_START;
      end
      ST_START: begin
        if (mid_start) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_bad_d = rx_s != parity_bit(PARITY_MAX_W'(shift_q), p_sel);
          state_d   = ST_STOP;
          cnt_d     = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          dout_d  = shift_q;
          perr_d  = par_bad_q;
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          armed_d = rx_s;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign d_out_rx   = dout_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, expected results queued,
// and every rx_valid pulse is matched against the head of the queue.
module tb_uart_rx;

  localparam int unsigned OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       bclk_rx;
  logic       p_sel;
  logic [7:0] d_out_rx;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int   checks    = 0;
  int   failures  = 0;
  int   valid_cnt = 0;
  int   div       = 4;
  int   tick_cnt  = 0;
  exp_t exp_q[$];

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .bclk_rx    (bclk_rx),
    .p_sel      (p_sel),
    .d_out_rx   (d_out_rx),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversampling tick: one pulse every div clocks (div == 1 keeps it high).
  initial begin
    bclk_rx = 1'b0;
    forever begin
      @(negedge clk);
      bclk_rx  = (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1 >= div) ? 0 : tick_cnt + 1;
    end
  end

  // Scoreboard: each valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid === 1'b1) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got data=%h perr=%b ferr=%b, required no valid", d_out_rx, parity_err, frame_err);
        end else begin
          e = exp_q.pop_front();
          if (d_out_rx !== e.data) begin
            failures++;
            $display("FAIL sb_data: got %h required %h", d_out_rx, e.data);
          end
          checks++;
          if (parity_err !== e.perr) begin
            failures++;
            $display("FAIL sb_parity_err: got %b required %b (data %h)", parity_err, e.perr, e.data);
          end
          checks++;
          if (frame_err !== e.ferr) begin
            failures++;
            $display("FAIL sb_frame_err: got %b required %b (data %h)", frame_err, e.ferr, e.data);
          end
        end
      end
    end
  end

  task automatic bit_wait();
    repeat (OS * div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_wait();
    end
    rx = par;
    bit_wait();
    rx = stop;
    bit_wait();
    rx = 1'b1;
  endtask

  function automatic logic exp_par(input logic [7:0] d, input logic ps);
    return ps ? (^d) : ~(^d);
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = (par != exp_par(d, p_sel));
    e.ferr = ~stop;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    p_sel = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (d_out_rx !== 8'h00) begin failures++; $display("FAIL reset_d_out: got %h required 00", d_out_rx); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", rx_valid); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b required 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b required 0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0;
    bit ok;
    v0    = valid_cnt;
    p_sel = 1'b1;
    push_exp(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain(ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL good_timeout: got pending=%0d required 0", exp_q.size()); end
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL good_pulses: got %0d required 1", valid_cnt - v0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy: got %b required 0", busy); end
  endtask

  task automatic test_parity_err();
    bit ok;
    p_sel = 1'b0;
    push_exp(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL parity_timeout: got pending=%0d required 0", exp_q.size()); end
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL parity_held: got %b required 1", parity_err); end
    p_sel = 1'b1;
  endtask

  task automatic test_frame_err_rearm();
    int v0;
    bit ok;
    bit busy_seen;
    v0 = valid_cnt;
    push_exp(8'h81, exp_par(8'h81, p_sel), 1'b0);
    send_frame(8'h81, exp_par(8'h81, p_sel), 1'b0);
    rx = 1'b0;
    busy_seen = 1'b0;
    repeat (3 * OS * div) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL stuck_low_busy: got %b required 0", busy_seen); end
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL stuck_low_pulses: got %0d required 1", valid_cnt - v0); end
    rx = 1'b1;
    bit_wait();
    push_exp(8'h42, exp_par(8'h42, p_sel), 1'b1);
    send_frame(8'h42, exp_par(8'h42, p_sel), 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rearm_timeout: got pending=%0d required 0", exp_q.size()); end
    checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL rearm_pulses: got %0d required 2", valid_cnt - v0); end
  endtask

  task automatic test_glitch();
    int v0;
    bit busy_seen;
    v0 = valid_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4 * div) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    rx = 1'b1;
    repeat (2 * OS * div) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_pulse: got %b required 1", busy_seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end: got %b required 0", busy); end
    checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d required 0", valid_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    bit ok;
    logic [7:0] frames [3];
    frames[0] = 8'h00;
    frames[1] = 8'hFF;
    frames[2] = 8'h55;
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      push_exp(frames[i], exp_par(frames[i], p_sel), 1'b1);
      send_frame(frames[i], exp_par(frames[i], p_sel), 1'b1);
    end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got pending=%0d required 0", exp_q.size()); end
    checks++; if (valid_cnt - v0 !== 3) begin failures++; $display("FAIL b2b_pulses: got %0d required 3", valid_cnt - v0); end
  endtask

  task automatic test_tick_continuous();
    bit ok;
    div = 1;
    repeat (4) @(negedge clk);
    push_exp(8'h5A, exp_par(8'h5A, p_sel), 1'b1);
    send_frame(8'h5A, exp_par(8'h5A, p_sel), 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL cont_tick_timeout: got pending=%0d required 0", exp_q.size()); end
    div = 4;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    bit ok;
    // Leave both error flags set so the reset clearing them is observable.
    push_exp(8'h96, ~exp_par(8'h96, p_sel), 1'b0);
    send_frame(8'h96, ~exp_par(8'h96, p_sel), 1'b0);
    bit_wait();
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL pre_reset_timeout: got pending=%0d required 0", exp_q.size()); end
    v0 = valid_cnt;
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 4; i++) begin
      rx = (8'hF0 >> i) & 8'h01;
      bit_wait();
    end
    rx = 1'b1;
    repeat (OS * div / 2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (d_out_rx !== 8'h00) begin failures++; $display("FAIL midrst_d_out: got %h required 00", d_out_rx); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL midrst_perr: got %b required 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_ferr: got %b required 0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    reset = 1'b1;
    bit_wait();
    push_exp(8'h0F, exp_par(8'h0F, p_sel), 1'b1);
    send_frame(8'h0F, exp_par(8'h0F, p_sel), 1'b1);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_reset_timeout: got pending=%0d required 0", exp_q.size()); end
    checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL midrst_pulses: got %0d required 1", valid_cnt - v0); end
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    p_sel = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err_rearm();
    test_glitch();
    test_back_to_back();
    test_tick_continuous();
    test_reset_mid_frame();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
